sr_fetch: RTL and testbench

SR_FETCH -- requirements
Module: sr_fetch

---
 rtl/sr_fetch.sv | 141 ++++++++++++++
 tb/tb_sr_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_fetch.sv
// Instruction fetch unit: credit-limited request stream into instruction memory, a 3-entry
// in-order response buffer, and redirect handling that discards stale in-flight responses.
module sr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pcPlus4_o,
   output logic        freeze_o
);

   localparam int unsigned DEPTH = 3;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic [31:0] pc_q, pc_d;
   logic [31:0] resp_pc_q, resp_pc_d;
   logic [1:0]  out_cnt_q, out_cnt_d;
   logic [1:0]  buf_cnt_q, buf_cnt_d;
   logic [1:0]  kill_cnt_q, kill_cnt_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [31:0] buf_instr_q [DEPTH];
   logic [31:0] buf_pc_q    [DEPTH];

   logic [2:0]  in_use;
   logic        credit_ok;
   logic        accept;
   logic        resp;
   logic        kill;
   logic        push;
   logic        pop;
   logic [31:0] redirect_target;
   logic        unused_redirect_lsb;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   assign redirect_target     = {redirect_pc_i[31:2], 2'b00};
   assign unused_redirect_lsb = ^redirect_pc_i[1:0];

   // Stale requests still occupy a credit until their response returns.
   assign in_use    = {1'b0, out_cnt_q} + {1'b0, buf_cnt_q};
   assign credit_ok = in_use < 3'd3;

   assign imem_req_o  = rst_n && !redirect_i && credit_ok;
   assign imem_addr_o = pc_q;

   assign accept = imem_req_o && imem_ack_i;
   assign resp   = imem_rvalid_i && (out_cnt_q != 2'd0);
   assign kill   = resp && (kill_cnt_q != 2'd0);
   assign push   = resp && !kill && !redirect_i;
   assign pop    = (buf_cnt_q != 2'd0) && !stall_i && !redirect_i;

   always_comb begin
      instr_o   = NOP;
      pc_o      = 32'h0000_0000;
      pcPlus4_o = 32'h0000_0000;
      freeze_o  = 1'b1;
      if (pop) begin
         instr_o   = buf_instr_q[rd_ptr_q];
         pc_o      = buf_pc_q[rd_ptr_q];
         pcPlus4_o = buf_pc_q[rd_ptr_q] + 32'd4;
         freeze_o  = 1'b0;
      end
   end

   always_comb begin
      pc_d       = pc_q;
      resp_pc_d  = resp_pc_q;
      out_cnt_d  = out_cnt_q + 2'(accept) - 2'(resp);
      buf_cnt_d  = buf_cnt_q;
      kill_cnt_d = kill_cnt_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;

      if (redirect_i) begin
         pc_d       = redirect_target;
         resp_pc_d  = redirect_target;
         buf_cnt_d  = 2'd0;
         rd_ptr_d   = 2'd0;
         wr_ptr_d   = 2'd0;
         // Every request still in flight after this cycle's response belongs to the old path.
         kill_cnt_d = out_cnt_q - 2'(resp);
      end else begin
         if (accept) begin
            pc_d = pc_q + 32'd4;
         end
         if (kill) begin
            kill_cnt_d = kill_cnt_q - 2'd1;
         end
         if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         buf_cnt_d = buf_cnt_q + 2'(push) - 2'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         out_cnt_q  <= 2'd0;
         buf_cnt_q  <= 2'd0;
         kill_cnt_q <= 2'd0;
         rd_ptr_q   <= 2'd0;
         wr_ptr_q   <= 2'd0;
      end else begin
         pc_q       <= pc_d;
         resp_pc_q  <= resp_pc_d;
         out_cnt_q  <= out_cnt_d;
         buf_cnt_q  <= buf_cnt_d;
         kill_cnt_q <= kill_cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Payload storage needs no reset; occupancy is tracked by buf_cnt_q.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_instr_q[wr_ptr_q] <= imem_rdata_i;
         buf_pc_q[wr_ptr_q]    <= resp_pc_q;
      end
   end

endmodule

// File: tb/tb_sr_fetch.sv
// Randomized bench for sr_fetch: a memory model plus an epoch-tagged scoreboard of the
// expected instruction stream, with directed phases for startup, stall, ack hold, redirect, reset.
module tb_sr_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic [31:0] pcPlus4_o;
   logic        freeze_o;

   sr_fetch #(.RESET_PC(RST_PC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ack_i   (imem_ack_i),
      .imem_rvalid_i(imem_rvalid_i),
      .imem_rdata_i (imem_rdata_i),
      .stall_i      (stall_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .instr_o      (instr_o),
      .pc_o         (pc_o),
      .pcPlus4_o    (pcPlus4_o),
      .freeze_o     (freeze_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          acc_cyc;
   } req_t;

   req_t        inflight[$];
   logic [63:0] buf_q[$];
   logic [31:0] fetch_pc;
   int          epoch;
   int          cyc;
   int          base_cyc;
   int          first_out;
   int          frz_cnt;
   int          n_checks;
   int          n_errors;

   int ack_pct, rv_pct, stall_pct, redir_pct, junk_pct;
   bit force_stall, force_nack;
   int trig;
   bit watch;
   logic [31:0] watch_pc;
   logic last_req, last_freeze;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      imem_ack_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      #1;
      check("rst_out", {instr_o, pc_o, pcPlus4_o}, {NOP, 32'h0, 32'h0});
      check("rst_freeze", 96'(freeze_o), 96'(1'b1));
      check("rst_req", 96'(imem_req_o), 96'(1'b0));
      check("rst_addr", 96'(imem_addr_o), 96'(RST_PC));
      inflight.delete();
      buf_q.delete();
      fetch_pc  = RST_PC;
      epoch     = 0;
      first_out = -1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_hold_addr", 96'(imem_addr_o), 96'(RST_PC));
      rst_n    = 1'b1;
      base_cyc = cyc;
      watch    = 1'b1;
      watch_pc = RST_PC;
   endtask

   // One cycle: drive at posedge+1, settle, check outputs and advance the model.
   task automatic step();
      req_t        h;
      logic        exp_req;
      logic        exp_freeze;
      logic [63:0] e;
      logic [95:0] exp_out;

      imem_ack_i    = force_nack ? 1'b0 : ($urandom_range(99) < ack_pct);
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
      if (inflight.size() > 0 && inflight[0].acc_cyc < cyc && $urandom_range(99) < rv_pct) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = mem_word(inflight[0].addr);
      end else if (inflight.size() == 0 && $urandom_range(99) < junk_pct) begin
         imem_rvalid_i = 1'b1;
      end
      stall_i       = force_stall ? 1'b1 : ($urandom_range(99) < stall_pct);
      redirect_i    = ($urandom_range(99) < redir_pct);
      redirect_pc_i = $urandom;
      if (trig == 1 && inflight.size() == 2) begin
         redirect_i    = 1'b1;
         redirect_pc_i = 32'h0000_0103;
         imem_rvalid_i = 1'b0;
         trig          = 0;
         watch         = 1'b1;
         watch_pc      = 32'h0000_0100;
      end else if (trig == 2 && imem_rvalid_i) begin
         redirect_i    = 1'b1;
         redirect_pc_i = 32'h0000_0202;
         trig          = 0;
         watch         = 1'b1;
         watch_pc      = 32'h0000_0200;
      end

      #3;
      exp_req = !redirect_i && ((inflight.size() + buf_q.size()) < 3);
      check("req", 96'(imem_req_o), 96'(exp_req));
      check("addr", 96'(imem_addr_o), 96'(fetch_pc));
      exp_freeze = (buf_q.size() == 0) || stall_i || redirect_i;
      check("freeze", 96'(freeze_o), 96'(exp_freeze));
      if (exp_freeze) begin
         exp_out = {NOP, 32'h0, 32'h0};
      end else begin
         e       = buf_q.pop_front();
         exp_out = {e[63:32], e[31:0], e[31:0] + 32'd4};
         if (watch) begin
            check("redir_first_pc", 96'(pc_o), 96'(watch_pc));
            watch = 1'b0;
         end
      end
      check("out", {instr_o, pc_o, pcPlus4_o}, exp_out);
      last_req    = imem_req_o;
      last_freeze = freeze_o;
      if (freeze_o) frz_cnt++;
      if (!freeze_o && first_out < 0) first_out = cyc - base_cyc;

      if (imem_rvalid_i && inflight.size() > 0) begin
         h = inflight.pop_front();
         if (!redirect_i && h.epoch == epoch) buf_q.push_back({mem_word(h.addr), h.addr});
      end
      if (redirect_i) begin
         epoch++;
         buf_q.delete();
         fetch_pc = {redirect_pc_i[31:2], 2'b00};
      end else if (exp_req && imem_ack_i) begin
         inflight.push_back('{addr: fetch_pc, epoch: epoch, acc_cyc: cyc});
         fetch_pc = fetch_pc + 32'd4;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] addr0;
      n_checks = 0;
      n_errors = 0;
      cyc = 0;
      trig = 0;
      watch = 1'b0;
      force_stall = 1'b0;
      force_nack = 1'b0;
      ack_pct = 100; rv_pct = 100; stall_pct = 0; redir_pct = 0; junk_pct = 0;
      rst_n = 1'b0;
      imem_ack_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
      @(posedge clk);
      #1;

      // Startup stream: first instruction two cycles after the first request, then one per cycle.
      do_reset();
      step();
      step();
      frz_cnt = 0;
      for (int i = 0; i < 20; i++) step();
      check("first_out_lat", 96'(first_out), 96'(2));
      check("stream_no_bubble", 96'(frz_cnt), 96'(0));

      // Stall fills the buffer and throttles requests.
      force_stall = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check("stall_req_low", 96'(last_req), 96'(1'b0));
      check("stall_frozen", 96'(last_freeze), 96'(1'b1));
      check("stall_buf_full", 96'(buf_q.size()), 96'(3));
      force_stall = 1'b0;
      for (int i = 0; i < 20; i++) step();

      // Ack withheld: address holds.
      addr0 = imem_addr_o;
      force_nack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("nack_addr_hold", 96'(imem_addr_o), 96'(addr0));
      end
      force_nack = 1'b0;
      for (int i = 0; i < 10; i++) step();

      // Redirect with two requests in flight, then redirect coinciding with a response.
      rv_pct = 50;
      for (int t = 1; t <= 2; t++) begin
         trig = t;
         for (int i = 0; i < 300 && (trig != 0 || watch); i++) step();
         check("redir_timeout", 96'({trig != 0, watch}), 96'(0));
         trig = 0;
         watch = 1'b0;
         for (int i = 0; i < 10; i++) step();
      end

      // Asynchronous reset with a full buffer.
      rv_pct = 100;
      force_stall = 1'b1;
      for (int i = 0; i < 50 && buf_q.size() < 3; i++) step();
      check("pre_reset_full", 96'(buf_q.size()), 96'(3));
      force_stall = 1'b0;
      do_reset();
      for (int i = 0; i < 10; i++) step();
      check("restart_lat", 96'(first_out), 96'(2));
      check("restart_watch", 96'(watch), 96'(1'b0));
      watch = 1'b0;

      // Random traffic with shifting knobs.
      for (int blk = 0; blk < 15; blk++) begin
         ack_pct   = $urandom_range(100, 30);
         rv_pct    = $urandom_range(100, 20);
         stall_pct = $urandom_range(60, 0);
         redir_pct = $urandom_range(10, 0);
         junk_pct  = $urandom_range(30, 0);
         for (int i = 0; i < 200; i++) step();
      end
      watch = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
